multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core. It consumes the decoded instruction fields and ALU flags from the datapath and produces every datapath control strobe and mux select, one state per cycle. It implements fetch, decode, execute, memory and writeback sequencing for R, I, load, store, branch, JAL, JALR, LUI and AUIPC.

---
 rtl/multicycle_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core.
// Each state lasts one cycle. The datapath strobes and mux selects are decoded
// from the current state. Write strobes are held low while reset is high, so an
// aborted instruction cannot perform a partial write.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResultLSB,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic [3:0] fsm_state
);

  typedef enum logic [3:0] {
    FETCH0    = 4'd0,
    FETCH1    = 4'd1,
    DECODE    = 4'd2,
    MEM_ADR   = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WAIT  = 4'd5,
    MEM_WB    = 4'd6,
    MEM_WRITE = 4'd7,
    EXEC_R    = 4'd8,
    EXEC_I    = 4'd9,
    ALU_WB    = 4'd10,
    BRANCH    = 4'd11,
    JAL_LINK  = 4'd12,
    JUMP      = 4'd13,
    JALR_ADR  = 4'd14,
    UPPER     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state_q, state_d;
  logic   branch_taken;
  logic   funct7_unused;

  // Only funct7[5] selects SUB/SRA; the other bits are ignored.
  assign funct7_unused = ^{funct7[6], funct7[4:0]};
  assign fsm_state     = state_q;

  // ALU operation for register and immediate arithmetic. funct7[5] selects SUB
  // only for register ops, because ADDI has no SUB form.
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3,
                                               input logic       f7b5,
                                               input logic       is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch outcome from the ALU flags. funct3 010/011 are not branches and are
  // never taken.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:          branch_taken = Zero;
      3'b001:          branch_taken = !Zero;
      3'b100, 3'b110:  branch_taken = ALUResultLSB;
      3'b101, 3'b111:  branch_taken = !ALUResultLSB;
      default:         branch_taken = 1'b0;
    endcase
  end

  // Next-state sequencing. The opcode comes from the latched IR, so it stays
  // stable after DECODE.
  always_comb begin
    state_d = FETCH0;
    case (state_q)
      FETCH0:   state_d = FETCH1;
      FETCH1:   state_d = DECODE;
      DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL_LINK;
          OP_JALR:           state_d = JALR_ADR;
          OP_LUI, OP_AUIPC:  state_d = UPPER;
          default:           state_d = FETCH0;
        endcase
      end
      MEM_ADR:  state_d = op_code[5] ? MEM_WRITE : MEM_READ;
      MEM_READ: state_d = MEM_WAIT;
      MEM_WAIT: state_d = MEM_WB;
      EXEC_R, EXEC_I, UPPER: state_d = ALU_WB;
      JALR_ADR: state_d = JAL_LINK;
      JAL_LINK: state_d = JUMP;
      default:  state_d = FETCH0;
    endcase
  end

  // State register. A synchronous reset returns the FSM to FETCH0.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH0;
    else       state_q <= state_d;
  end

  // Decode the control outputs from the current state. Write strobes are gated
  // off while reset is high.
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    IR_write    = 1'b0;
    reg_write   = 1'b0;
    PC_write    = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    case (state_q)
      FETCH1: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        result_src = 2'd2;
      end
      DECODE: begin
        // The branch or JAL target is computed here and held in ALU_out.
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        if (op_code == OP_BRANCH)   imm_src = IMM_B;
        else if (op_code == OP_JAL) imm_src = IMM_J;
      end
      MEM_ADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src   = op_code[5] ? IMM_S : IMM_I;
      end
      MEM_READ, MEM_WAIT: adr_src = 1'b1;
      MEM_WB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXEC_R: begin
        alu_src_a   = 2'd2;
        alu_control = alu_op_decode(funct3, funct7[5], 1'b1);
      end
      EXEC_I: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_op_decode(funct3, funct7[5], 1'b0);
      end
      UPPER: begin
        alu_src_a = op_code[5] ? 2'd3 : 2'd1;
        alu_src_b = 2'd1;
        imm_src   = IMM_U;
      end
      ALU_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'd2;
        if (!funct3[2])     alu_control = ALU_SUB;
        else if (!funct3[1]) alu_control = ALU_SLT;
        else                alu_control = ALU_SLTU;
        PC_write = branch_taken;
      end
      JAL_LINK: begin
        // Keep the ALU inputs steady so ALU_out still holds the jump target.
        reg_write  = 1'b1;
        result_src = 2'd3;
        alu_src_b  = 2'd1;
        if (op_code[3]) begin
          alu_src_a = 2'd1;
          imm_src   = IMM_J;
        end else begin
          alu_src_a = 2'd2;
        end
      end
      JALR_ADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      JUMP: PC_write = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_write = 1'b0;
      IR_write  = 1'b0;
      reg_write = 1'b0;
      PC_write  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The stimulus pushes the
// hand-computed output vector expected for each cycle. A monitor pops it at the
// falling edge and compares it with the DUT outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       ALUResultLSB;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control, fsm_state;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .ALUResultLSB(ALUResultLSB), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // The monitor compares each expectation with the outputs in mid-cycle.
  always @(negedge clk) begin
    logic [21:0] act;
    logic [21:0] expv;
    string nm;
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      nm   = name_q.pop_front();
      act  = {fsm_state, adr_src, mem_write, IR_write, reg_write, PC_write,
              result_src, alu_src_a, alu_src_b, imm_src, alu_control};
      n_compared++;
      if (act !== expv) begin
        n_mismatched++;
        $display("FAIL %s: got st=%0d vec=%h, expected st=%0d vec=%h",
                 nm, act[21:18], act, expv[21:18], expv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected outputs for the current cycle, then move to the next cycle.
  task automatic e(input string nm, input logic [3:0] st, input logic adr, input logic mw,
                   input logic irw, input logic rw, input logic pcw, input logic [1:0] rs,
                   input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] imm,
                   input logic [3:0] alu);
    exp_q.push_back({st, adr, mw, irw, rw, pcw, rs, sa, sb, imm, alu});
    name_q.push_back(nm);
    step();
  endtask

  task automatic fetch_decode(input logic [2:0] imm);
    e("fetch0", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    e("fetch1", 1, 0, 0, 1, 0, 1, 2'd2, 2'd0, 2'd0, 3'd0, 4'd0);
    e("decode", 2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 4'd0);
  endtask

  task automatic set_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic lsb);
    op_code = op; funct3 = f3; funct7 = f7; Zero = z; ALUResultLSB = lsb;
    $display("instr %s op=%b f3=%b f7=%b Zero=%b LSB=%b", nm, op, f3, f7, z, lsb);
  endtask

  initial begin
    reset = 1'b1; op_code = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; ALUResultLSB = 1'b0;
    step();
    repeat (3) e("reset_hold", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    reset = 1'b0;

    set_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0, 0);
    fetch_decode(3'd0);
    e("exec_r_sub", 8, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'b0001);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("sltu", 7'b0110011, 3'b011, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("exec_r_sltu", 8, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'b1001);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("addi_f7b5", 7'b0010011, 3'b000, 7'b0100000, 0, 0);
    fetch_decode(3'd0);
    e("exec_i_add", 9, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'b0000);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 0, 0);
    fetch_decode(3'd0);
    e("exec_i_sra", 9, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'b0111);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("lw", 7'b0000011, 3'b010, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("mem_adr_load", 3, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
    e("mem_read", 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    e("mem_wait", 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    e("mem_wb", 6, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("sw", 7'b0100011, 3'b010, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("mem_adr_store", 3, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0);
    e("mem_write", 7, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("beq_taken", 7'b1100011, 3'b000, 7'b0000000, 1, 0);
    fetch_decode(3'd2);
    e("branch_beq_t", 11, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 3'd0, 4'b0001);

    set_instr("beq_not", 7'b1100011, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd2);
    e("branch_beq_nt", 11, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'b0001);

    set_instr("bne_taken", 7'b1100011, 3'b001, 7'b0000000, 0, 0);
    fetch_decode(3'd2);
    e("branch_bne_t", 11, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 3'd0, 4'b0001);

    set_instr("bltu_taken", 7'b1100011, 3'b110, 7'b0000000, 0, 1);
    fetch_decode(3'd2);
    e("branch_bltu_t", 11, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 3'd0, 4'b1001);

    set_instr("bge_not", 7'b1100011, 3'b101, 7'b0000000, 0, 1);
    fetch_decode(3'd2);
    e("branch_bge_nt", 11, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'b1000);

    set_instr("jal", 7'b1101111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd3);
    e("jal_link", 12, 0, 0, 0, 1, 0, 2'd3, 2'd1, 2'd1, 3'd3, 4'd0);
    e("jump", 13, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("jalr", 7'b1100111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("jalr_adr", 14, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
    e("jalr_link", 12, 0, 0, 0, 1, 0, 2'd3, 2'd2, 2'd1, 3'd0, 4'd0);
    e("jump", 13, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("lui", 7'b0110111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("upper_lui", 15, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd4, 4'd0);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("upper_auipc", 15, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd4, 4'd0);
    e("alu_wb", 10, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    set_instr("unknown", 7'b1111111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd0);

    set_instr("lw_reset_read", 7'b0000011, 3'b010, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("mem_adr_load", 3, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
    reset = 1'b1;
    e("mem_read_rst", 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    reset = 1'b0;

    set_instr("lw_reset_wb", 7'b0000011, 3'b010, 7'b0000000, 0, 0);
    fetch_decode(3'd0);
    e("mem_adr_load", 3, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0);
    e("mem_read", 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    e("mem_wait", 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    reset = 1'b1;
    e("mem_wb_rst", 6, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0);
    reset = 1'b0;

    set_instr("jal_reset_jump", 7'b1101111, 3'b000, 7'b0000000, 0, 0);
    fetch_decode(3'd3);
    e("jal_link", 12, 0, 0, 0, 1, 0, 2'd3, 2'd1, 2'd1, 3'd3, 4'd0);
    reset = 1'b1;
    e("jump_rst", 13, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);
    reset = 1'b0;
    e("fetch0_after_rst", 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
